// File: rtl/xdma_pkg.sv
// rtl/xdma_pkg.sv - shared types and constants for the xDMA finish path
package xdma_pkg;

    localparam int unsigned IdWidth   = 8;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;

    typedef logic [IdWidth-1:0]   xdma_id_t;
    typedef logic [AddrWidth-1:0] xdma_addr_t;
    typedef logic [DataWidth-1:0] xdma_data_t;

    typedef struct packed {
        xdma_id_t   dma_id;
        xdma_addr_t from;
    } xdma_to_remote_finish_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_B
    } xdma_finish_tx_state_e;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO, registered storage, no fall-through
module fifo_v3 #(
    parameter int unsigned DEPTH = 2,
    parameter type dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic testmode_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    dtype             mem_q [DEPTH];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;
    logic             unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == AddrW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == AddrW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/xdma_finish_tx.sv
// rtl/xdma_finish_tx.sv - sends xDMA finish packets upstream as single-beat AXI writes
// Optional retry on error response: define XDMA_FINISH_TX_RETRY_EN.
module xdma_finish_tx #(
    parameter type id_t                    = xdma_pkg::xdma_id_t,
    parameter type addr_t                  = xdma_pkg::xdma_addr_t,
    parameter type data_t                  = xdma_pkg::xdma_data_t,
    parameter type xdma_to_remote_finish_t = xdma_pkg::xdma_to_remote_finish_t,
    parameter int unsigned FifoDepth       = 2,
    parameter int unsigned MaxRetry        = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  addr_t                      cluster_base_addr_i,
    input  logic                       finish_valid_i,
    output logic                       finish_ready_o,
    input  id_t                        finish_dma_id_i,
    input  addr_t                      finish_addr_i,
    output addr_t                      aw_addr_o,
    output logic                       aw_valid_o,
    input  logic                       aw_ready_i,
    output data_t                      w_data_o,
    output logic [$bits(data_t)/8-1:0] w_strb_o,
    output logic                       w_last_o,
    output logic                       w_valid_o,
    input  logic                       w_ready_i,
    input  logic [1:0]                 b_resp_i,
    input  logic                       b_valid_i,
    output logic                       b_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    import xdma_pkg::*;

    localparam int unsigned PktW = $bits(xdma_to_remote_finish_t);

    typedef struct packed {
        id_t   dma_id;
        addr_t addr;
        addr_t from;
    } req_t;

    req_t  push_req, head;
    logic  fifo_full, fifo_empty, fifo_push, fifo_pop;
    xdma_to_remote_finish_t pkt;
    data_t w_data_d;
    logic  resp_ok;

    xdma_finish_tx_state_e state_q;
    logic  aw_valid_q, w_valid_q, b_ready_q, done_q, err_q;
    addr_t aw_addr_q;
    data_t w_data_q;

`ifdef XDMA_FINISH_TX_RETRY_EN
    localparam int unsigned RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
    logic [RetryW-1:0] retry_cnt_q;
`else
    localparam int unsigned unused_max_retry = MaxRetry;
`endif

    // The origin address is captured at push so it matches the moment the finish was raised.
    assign push_req  = '{dma_id: finish_dma_id_i, addr: finish_addr_i, from: cluster_base_addr_i};
    assign fifo_push = finish_valid_i && finish_ready_o;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    fifo_v3 #(
        .DEPTH (FifoDepth),
        .dtype (req_t)
    ) i_req_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .data_i     (push_req),
        .push_i     (fifo_push),
        .data_o     (head),
        .pop_i      (fifo_pop)
    );

    assign pkt = xdma_to_remote_finish_t'({head.dma_id, head.from});

    always_comb begin
        w_data_d           = '0;
        w_data_d[PktW-1:0] = pkt;
    end

    assign resp_ok = (b_resp_i == RESP_OKAY) || (b_resp_i == RESP_EXOKAY);

    // A cleared *_valid_q inside SEND doubles as the per-channel done flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
`ifdef XDMA_FINISH_TX_RETRY_EN
            retry_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        aw_addr_q   <= head.addr;
                        w_data_q    <= w_data_d;
                        aw_valid_q  <= 1'b1;
                        w_valid_q   <= 1'b1;
`ifdef XDMA_FINISH_TX_RETRY_EN
                        retry_cnt_q <= '0;
`endif
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (aw_ready_i) aw_valid_q <= 1'b0;
                    if (w_ready_i)  w_valid_q  <= 1'b0;
                    if ((!aw_valid_q || aw_ready_i) && (!w_valid_q || w_ready_i)) begin
                        b_ready_q <= 1'b1;
                        state_q   <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (b_valid_i) begin
                        b_ready_q <= 1'b0;
                        if (resp_ok) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
`ifdef XDMA_FINISH_TX_RETRY_EN
                            if (retry_cnt_q < RetryW'(MaxRetry)) begin
                                retry_cnt_q <= retry_cnt_q + 1'b1;
                                aw_valid_q  <= 1'b1;
                                w_valid_q   <= 1'b1;
                                state_q     <= ST_SEND;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
`else
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
`endif
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign finish_ready_o = !fifo_full;
    assign aw_addr_o      = aw_addr_q;
    assign aw_valid_o     = aw_valid_q;
    assign w_data_o       = w_data_q;
    assign w_strb_o       = '1;
    assign w_last_o       = 1'b1;
    assign w_valid_o      = w_valid_q;
    assign b_ready_o      = b_ready_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign busy_o         = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_xdma_finish_tx.sv
// tb/tb_xdma_finish_tx.sv - directed scoreboard bench for xdma_finish_tx
module tb_xdma_finish_tx;
    import xdma_pkg::*;

`ifdef XDMA_FINISH_TX_RETRY_EN
    localparam int ExpPairs = 4;
`else
    localparam int ExpPairs = 1;
`endif

    typedef struct {
        bit          err;
        logic [31:0] addr;
        logic [63:0] data;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] cluster_base_addr_i;
    logic        finish_valid_i;
    logic        finish_ready_o;
    logic [7:0]  finish_dma_id_i;
    logic [31:0] finish_addr_i;
    logic [31:0] aw_addr_o;
    logic        aw_valid_o;
    logic        aw_ready_i = 1'b0;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o;
    logic        w_valid_o;
    logic        w_ready_i = 1'b0;
    logic [1:0]  b_resp_i = 2'b00;
    logic        b_valid_i = 1'b0;
    logic        b_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    xdma_finish_tx dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .cluster_base_addr_i (cluster_base_addr_i),
        .finish_valid_i      (finish_valid_i),
        .finish_ready_o      (finish_ready_o),
        .finish_dma_id_i     (finish_dma_id_i),
        .finish_addr_i       (finish_addr_i),
        .aw_addr_o           (aw_addr_o),
        .aw_valid_o          (aw_valid_o),
        .aw_ready_i          (aw_ready_i),
        .w_data_o            (w_data_o),
        .w_strb_o            (w_strb_o),
        .w_last_o            (w_last_o),
        .w_valid_o           (w_valid_o),
        .w_ready_i           (w_ready_i),
        .b_resp_i            (b_resp_i),
        .b_valid_i           (b_valid_i),
        .b_ready_o           (b_ready_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o)
    );

    int   errors = 0;
    int   checks = 0;
    int   aw_lat = 0, w_lat = 0, b_lat = 0;
    logic [1:0] resp_mode = RESP_OKAY;

    int   aw_hs_cnt = 0, w_hs_cnt = 0, done_cnt = 0, err_cnt = 0, viol_cnt = 0;
    ev_t  comp_log[$];
    ev_t  sb[$];
    int   comp_rd = 0;

    // Responder plus monitor: drives ready/B at the falling edge, records completions.
    int   aw_wait = 0, w_wait = 0, b_wait = 0;
    bit   aw_got = 0, w_got = 0, aw_pend = 0, w_pend = 0;
    logic [31:0] aw_prev = '0;
    logic [63:0] w_prev = '0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            aw_ready_i = 1'b0;
            w_ready_i  = 1'b0;
            b_valid_i  = 1'b0;
            aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (aw_pend && (aw_valid_o !== 1'b1 || aw_addr_o !== aw_prev)) viol_cnt++;
            if (w_pend && (w_valid_o !== 1'b1 || w_data_o !== w_prev)) viol_cnt++;
            if (aw_valid_o) begin aw_ready_i = (aw_wait >= aw_lat); aw_wait++; end
            else begin aw_ready_i = 1'b0; aw_wait = 0; end
            if (w_valid_o) begin w_ready_i = (w_wait >= w_lat); w_wait++; end
            else begin w_ready_i = 1'b0; w_wait = 0; end
            b_valid_i = 1'b0;
            b_resp_i  = RESP_OKAY;
            if (aw_got && w_got) begin
                if (b_wait >= b_lat) begin b_valid_i = 1'b1; b_resp_i = resp_mode; end
                else b_wait++;
            end
            if (aw_valid_o && aw_ready_i) begin aw_got = 1; aw_hs_cnt++; end
            if (w_valid_o && w_ready_i) begin w_got = 1; w_hs_cnt++; end
            aw_pend = aw_valid_o && !aw_ready_i;
            w_pend  = w_valid_o && !w_ready_i;
            aw_prev = aw_addr_o;
            w_prev  = w_data_o;
            if (b_valid_i && b_ready_o) begin aw_got = 0; w_got = 0; b_wait = 0; end
            if (done_o || err_o) comp_log.push_back('{err: err_o, addr: aw_addr_o, data: w_data_o});
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] id, input logic [31:0] addr, input bit exp_err,
                        output bit blocked);
        int n;
        finish_valid_i  = 1'b1;
        finish_dma_id_i = id;
        finish_addr_i   = addr;
        sb.push_back('{err: exp_err, addr: addr, data: {24'b0, id, cluster_base_addr_i}});
        blocked = !finish_ready_o;
        n = 0;
        while (!finish_ready_o && n < 200) begin @(negedge clk_i); n++; end
        chk("push_accept", 64'(finish_ready_o), 64'(1));
        @(posedge clk_i);
        @(negedge clk_i);
        finish_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 1000) begin @(negedge clk_i); n++; end
        chk("idle_timeout", 64'(busy_o), 64'(0));
        @(negedge clk_i);
    endtask

    task automatic drain();
        ev_t got, exp;
        while (comp_rd < comp_log.size()) begin
            got = comp_log[comp_rd];
            comp_rd++;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'(1), 64'(0));
            end else begin
                exp = sb.pop_front();
                chk("sb_addr", 64'(got.addr), 64'(exp.addr));
                chk("sb_data", got.data, exp.data);
                chk("sb_kind", 64'(got.err), 64'(exp.err));
            end
        end
        chk("sb_left", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        bit blk;
        int aw0, w0, d0, e0;
        rst_ni              = 1'b0;
        finish_valid_i      = 1'b0;
        finish_dma_id_i     = '0;
        finish_addr_i       = '0;
        cluster_base_addr_i = 32'h2000_0000;
        repeat (3) @(negedge clk_i);
        chk("rst_aw_valid", 64'(aw_valid_o), 64'(0));
        chk("rst_w_valid", 64'(w_valid_o), 64'(0));
        chk("rst_b_ready", 64'(b_ready_o), 64'(0));
        chk("rst_flags", 64'({done_o, err_o, busy_o}), 64'(0));
        chk("rst_aw_addr", 64'(aw_addr_o), 64'(0));
        chk("rst_w_data", w_data_o, 64'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", 64'(finish_ready_o), 64'(1));

        // Single request, everything ready
        push(8'd5, 32'h1000_0040, 1'b0, blk);
        chk("t1_aw_idle", 64'(aw_valid_o), 64'(0));
        @(negedge clk_i);
        chk("t2_aw_valid", 64'(aw_valid_o), 64'(1));
        chk("t2_w_valid", 64'(w_valid_o), 64'(1));
        chk("t2_aw_addr", 64'(aw_addr_o), 64'h1000_0040);
        chk("t2_w_data", w_data_o, 64'h0000_0005_2000_0000);
        chk("t2_strb_last", 64'({w_strb_o, w_last_o}), 64'h1ff);
        @(negedge clk_i);
        chk("t3_done_low", 64'(done_o), 64'(0));
        chk("t3_b_ready", 64'(b_ready_o), 64'(1));
        @(negedge clk_i);
        chk("t4_done", 64'(done_o), 64'(1));
        wait_idle();
        drain();

        // AW late by three cycles
        aw_lat = 3;
        push(8'd1, 32'h1000_0100, 1'b0, blk);
        @(negedge clk_i);
        chk("awl_both_valid", 64'({aw_valid_o, w_valid_o}), 64'b11);
        @(negedge clk_i);
        chk("awl_w_drop", 64'({aw_valid_o, w_valid_o}), 64'b10);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("awl_aw_hold", 64'(aw_valid_o), 64'(1));
        chk("awl_no_waitb", 64'(b_ready_o), 64'(0));
        @(negedge clk_i);
        chk("awl_waitb", 64'(b_ready_o), 64'(1));
        wait_idle();
        drain();

        // W late by three cycles
        aw_lat = 0;
        w_lat  = 3;
        push(8'd2, 32'h1000_0200, 1'b0, blk);
        @(negedge clk_i);
        chk("wl_both_valid", 64'({aw_valid_o, w_valid_o}), 64'b11);
        @(negedge clk_i);
        chk("wl_aw_drop", 64'({aw_valid_o, w_valid_o}), 64'b01);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("wl_no_waitb", 64'(b_ready_o), 64'(0));
        @(negedge clk_i);
        chk("wl_waitb", 64'(b_ready_o), 64'(1));
        wait_idle();
        drain();

        // Queue fills behind a stalled B; the third queued push must wait
        w_lat = 0;
        b_lat = 10;
        d0 = done_cnt;
        cluster_base_addr_i = 32'h2000_1000;
        push(8'd10, 32'h1000_1000, 1'b0, blk);
        repeat (2) @(negedge clk_i);
        chk("q_in_waitb", 64'(b_ready_o), 64'(1));
        push(8'd11, 32'h1000_1100, 1'b0, blk);
        chk("q_push1_open", 64'(blk), 64'(0));
        push(8'd12, 32'h1000_1200, 1'b0, blk);
        chk("q_push2_open", 64'(blk), 64'(0));
        push(8'd13, 32'h1000_1300, 1'b0, blk);
        chk("q_push3_blocked", 64'(blk), 64'(1));
        wait_idle();
        chk("q_done_cnt", 64'(done_cnt - d0), 64'(4));
        drain();

        // Error response on every attempt
        b_lat     = 0;
        resp_mode = RESP_SLVERR;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; d0 = done_cnt; e0 = err_cnt;
        push(8'd7, 32'h1000_2000, 1'b1, blk);
        wait_idle();
        chk("err_aw_pairs", 64'(aw_hs_cnt - aw0), 64'(ExpPairs));
        chk("err_w_pairs", 64'(w_hs_cnt - w0), 64'(ExpPairs));
        chk("err_pulses", 64'(err_cnt - e0), 64'(1));
        chk("err_no_done", 64'(done_cnt - d0), 64'(0));
        drain();

        // Reset while in SEND with one entry queued
        resp_mode = RESP_OKAY;
        aw_lat = 20;
        w_lat  = 20;
        push(8'd20, 32'h1000_3000, 1'b0, blk);
        push(8'd21, 32'h1000_3100, 1'b0, blk);
        chk("rs_in_send", 64'({aw_valid_o, w_valid_o, busy_o}), 64'b111);
        #2 rst_ni = 1'b0;
        #1;
        chk("rs_valid_drop", 64'({aw_valid_o, w_valid_o}), 64'b00);
        repeat (2) @(negedge clk_i);
        sb.delete();
        comp_rd = comp_log.size();
        aw_lat = 0;
        w_lat  = 0;
        aw0 = aw_hs_cnt;
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("rs_busy_low", 64'(busy_o), 64'(0));
        chk("rs_no_write", 64'(aw_hs_cnt - aw0), 64'(0));
        chk("rs_no_done", 64'(comp_log.size() - comp_rd), 64'(0));

        chk("axi_stability", 64'(viol_cnt), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
